// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared state encoding and constants for the fetch controller
package pc_fetch_ctrl_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  localparam int PC_INC = 4;
  localparam int CNT_W = 16;
endpackage

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// sat_counter: increment-enable counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  // count enabled events, stopping once every bit is set
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (en_i && !(&cnt_q)) cnt_q <= cnt_q + W'(1);
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter sequencing with redirect flush, halt and redirect statistics
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             Halt,
  output logic [PC_W-1:0]  Cur_PC,
  output logic             fetch_valid,
  output logic             Flush,
  output logic             halted,
  output logic             misaligned,
  output logic [CNT_W-1:0] redirect_cnt
);
  state_t state_q;
  logic [PC_W-1:0] pc_q, tgt, seq_pc;
  logic fv_q, flush_q, halted_q, mis_q, redir;
  logic unused_br;
  assign unused_br = ^BrPC;
  assign tgt = {BrPC[PC_W-1:2], 2'b00};
  assign seq_pc = stall ? pc_q : pc_q + PC_W'(PC_INC);
  // only RUN accepts a redirect; the EX instruction seen during FLUSH is wrong-path
  assign redir = (state_q == RUN) && PcSel && !Halt;
  // fetch state machine; every output comes straight from a register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      fv_q     <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (Halt) begin
            state_q  <= HALT;
            pc_q     <= tgt;
            fv_q     <= 1'b0;
            flush_q  <= 1'b1;
            halted_q <= 1'b1;
          end else if (PcSel) begin
            state_q <= FLUSH;
            pc_q    <= tgt;
            fv_q    <= 1'b1;
            flush_q <= 1'b1;
            mis_q   <= mis_q | (|BrPC[1:0]);
          end else begin
            pc_q    <= seq_pc;
            fv_q    <= 1'b1;
            flush_q <= 1'b0;
          end
        end
        FLUSH: begin
          state_q <= RUN;
          pc_q    <= seq_pc;
          fv_q    <= 1'b1;
          flush_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (reset),
    .en_i (redir),
    .cnt_o(redirect_cnt)
  );
  assign Cur_PC      = pc_q;
  assign fetch_valid = fv_q;
  assign Flush       = flush_q;
  assign halted      = halted_q;
  assign misaligned  = mis_q;
endmodule
